regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = none
- ZERO_REG, 1, 1 = register 0 hardwired to zero
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on posedge
- reset, in, 1, synchronous, active-high
- rdAddr, in, NUM_RD*ADDR_W, packed read addresses; port k uses slice k
- rdData, out, NUM_RD*DATA_W, packed read data; port k uses slice k
- rdBusy, out, NUM_RD, scoreboard busy flag of each read address
- wrEn0, in, 1, write port 0 enable
- wrAddr0, in, ADDR_W, write port 0 address
- wrData0, in, DATA_W, write port 0 data
- wrEn1, in, 1, write port 1 enable
- wrAddr1, in, ADDR_W, write port 1 address
- wrData1, in, DATA_W, write port 1 data
- issueEn, in, 1, mark a destination pending
- issueAddr, in, ADDR_W, destination to mark busy
REQ-003 Clock and reset SHALL be one clock (clk) and a synchronous, active-high reset (reset).

Function
REQ-004 Reads SHALL be combinational: rdData slice k = register[rdAddr slice k], with zero-cycle latency.
REQ-005 Writes SHALL commit on posedge clk when the port's wrEn is 1.
REQ-006 If wrEn0 and wrEn1 are both 1 with equal addresses, port 1 data SHALL be stored.
REQ-007 With BYPASS=1, a read matching an enabled write address SHALL return that write's data in the same cycle; port 1 SHALL take precedence over port 0.
REQ-008 With BYPASS=0, a read SHALL return the pre-write value until the following cycle.
REQ-009 With ZERO_REG=1:
- writes to address 0 SHALL be ignored
- reads of address 0 SHALL return 0, including the bypass path
- rdBusy for address 0 SHALL be 0
- issue to address 0 SHALL be ignored
REQ-010 The scoreboard SHALL hold one busy bit per register.
- issueEn sets busy[issueAddr] at posedge.
- Each enabled write clears busy[wrAddr] at posedge.
REQ-011 If issue and write target the same address in one cycle, set SHALL win, so the register stays busy for the new producer.
REQ-012 rdBusy slice k SHALL equal busy[rdAddr k] as registered; it SHALL NOT be bypassed from same-cycle writes or issues.
REQ-013 All address widths SHALL be exact, so no out-of-range access is possible.

Reset
REQ-014 While reset=1 at posedge, all registers and all busy bits SHALL clear to 0, and writes and issues in that cycle SHALL be ignored.
REQ-015 After reset, rdData SHALL be 0 and rdBusy SHALL be 0 for every port until the first write or issue.
REQ-016 Reset asserted mid-operation SHALL discard pending scoreboard state with no partial writes.

Structure
REQ-017 Package regfile_pkg SHALL hold the default DATA_W and ADDR_W constants and the register address type.
REQ-018 The busy-bit array and its set/clear logic SHALL be a sub-module named regfile_scoreboard; storage and bypass SHALL stay in regfile_mp.

Verification
REQ-019 Reset, then read every address on all ports -> rdData=0 and rdBusy=0.
REQ-020 wrEn0=1, wrAddr0=5, wrData0=0xDEADBEEF, with rdAddr port 0 = 5 in the same cycle:
- BYPASS=1 -> 0xDEADBEEF in that cycle.
- BYPASS=0 -> 0 in that cycle, then 0xDEADBEEF next cycle.
REQ-021 Both ports write address 7 (0x11111111 on port 0, 0x22222222 on port 1) -> next-cycle read of 7 = 0x22222222.
REQ-022 Write 0xFFFFFFFF to address 0 with ZERO_REG=1 -> read of 0 = 0, including in the same cycle; issue to 0 -> rdBusy=0.
REQ-023 Scoreboard sequence on address 9:
- issue 9 -> rdBusy=1 next cycle.
- write 9 plus issue 9 in the same cycle -> still busy.
- write 9 alone -> rdBusy=0 next cycle.
REQ-024 Write address 3 = 0xA5A5A5A5 and issue 3, then assert reset for one cycle -> read of 3 = 0 and rdBusy=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-ported register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// One busy bit per register: issue sets, writes clear, set wins on collision.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     wr_en0,
    input  logic [ADDR_W-1:0]        wr_addr0,
    input  logic                     wr_en1,
    input  logic [ADDR_W-1:0]        wr_addr1,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] busy_q;

    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    always_comb begin
        busy_d = busy_q;
        if (wr_en0) busy_d[wr_addr0] = 1'b0;
        if (wr_en1) busy_d[wr_addr1] = 1'b0;
        // Applied after the clears so a new producer keeps the register busy.
        if (issue_en) busy_d[issue_addr] = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    // Registered view only; same-cycle issues and writes are not forwarded.
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy[k] = busy_q[rd_addr[k*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file: combinational reads with optional write bypass,
// two write ports (port 1 wins on collision) and a pending-write scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    output logic [NUM_RD*DATA_W-1:0] rdData,
    output logic [NUM_RD-1:0]        rdBusy,
    input  logic                     wrEn0,
    input  logic [ADDR_W-1:0]        wrAddr0,
    input  logic [DATA_W-1:0]        wrData0,
    input  logic                     wrEn1,
    input  logic [ADDR_W-1:0]        wrAddr1,
    input  logic [DATA_W-1:0]        wrData1,
    input  logic                     issueEn,
    input  logic [ADDR_W-1:0]        issueAddr
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic wr_ok0;
    logic wr_ok1;
    logic issue_ok;

    logic [ADDR_W-1:0] rd_addr_k;
    logic [DATA_W-1:0] rd_val_k;

    always_comb begin
        wr_ok0   = wrEn0   && !((ZERO_REG != 0) && (wrAddr0   == '0));
        wr_ok1   = wrEn1   && !((ZERO_REG != 0) && (wrAddr1   == '0));
        issue_ok = issueEn && !((ZERO_REG != 0) && (issueAddr == '0));
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_ok0) mem_d[wrAddr0] = wrData0;
        if (wr_ok1) mem_d[wrAddr1] = wrData1;
    end

    // NOTE: the storage array is reset on purpose: every register must read 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) mem_q <= '{default: '0};
        else       mem_q <= mem_d;
    end

    always_comb begin
        rdData    = '0;
        rd_addr_k = '0;
        rd_val_k  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr_k = rdAddr[k*ADDR_W +: ADDR_W];
            rd_val_k  = mem_q[rd_addr_k];
            // Forward writes that are about to commit; port 1 is checked last so it wins.
            if ((BYPASS != 0) && !reset) begin
                if (wr_ok0 && (wrAddr0 == rd_addr_k)) rd_val_k = wrData0;
                if (wr_ok1 && (wrAddr1 == rd_addr_k)) rd_val_k = wrData1;
            end
            if ((ZERO_REG != 0) && (rd_addr_k == '0)) rd_val_k = '0;
            rdData[k*DATA_W +: DATA_W] = rd_val_k;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .issue_en   (issue_ok),
        .issue_addr (issueAddr),
        .wr_en0     (wr_ok0),
        .wr_addr0   (wrAddr0),
        .wr_en1     (wr_ok1),
        .wr_addr1   (wrAddr1),
        .rd_addr    (rdAddr),
        .rd_busy    (rdBusy)
    );

endmodule
